// File: rtl/jpiso_tx.sv
// jpiso_tx: parallel-in serial-out transmitter with valid/ready load and gapless back-to-back words
module jpiso_tx #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] din,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             accept;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         shreg <= shreg_n;
         cnt   <= cnt_n;
      end
   end
   always_comb begin
      busy       = state == SHIFT;
      sout_valid = busy;
      sout_last  = busy && cnt == '0;
      load_ready = !busy || sout_last;
      accept     = load_valid && load_ready;
      sout       = busy ? (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]) : 1'b0;
      state_n    = state;
      shreg_n    = shreg;
      cnt_n      = cnt;
      if (accept) begin
         state_n = SHIFT;
         shreg_n = din;
         cnt_n   = CW'(WIDTH - 1);
      end else if (sout_last) begin
         state_n = IDLE;
         shreg_n = '0;
      end else if (busy) begin
         shreg_n = LSB_FIRST ? shreg >> 1 : shreg << 1;
         cnt_n   = cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_jpiso_tx.sv
// tb_jpiso_tx: directed and random checks of jpiso_tx (MSB-first and LSB-first) against a bit-queue model
module tb_jpiso_tx;
   logic       clk = 1'b0, rst = 1'b1;
   logic       lv_m = 1'b0, lv_l = 1'b0;
   logic [7:0] din_m = 'x, din_l = 'x;
   logic       rdy_m, sout_m, sv_m, sl_m, busy_m;
   logic       rdy_l, sout_l, sv_l, sl_l, busy_l;
   logic       chain_q;
   bit         qm[$], ql[$];
   bit         acc_m, acc_l, prev_m;
   int         n_assert = 0, n_fail = 0, waited;
   logic [7:0] col, col_l;

   jpiso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .load_valid(lv_m), .load_ready(rdy_m), .din(din_m),
      .sout(sout_m), .sout_valid(sv_m), .sout_last(sl_m), .busy(busy_m));
   jpiso_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .load_valid(lv_l), .load_ready(rdy_l), .din(din_l),
      .sout(sout_l), .sout_valid(sv_l), .sout_last(sl_l), .busy(busy_l));

   always #5 clk = ~clk;
   // downstream D flip-flop stage fed by the serial line
   always @(posedge clk) chain_q <= sout_m;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // model: queue holds the bits still to appear, front = bit on the line now
   task automatic check_outs();
      chk("m_sout", sout_m, qm.size() > 0 ? qm[0] : 1'b0);
      chk("m_valid", sv_m, qm.size() > 0);
      chk("m_busy", busy_m, qm.size() > 0);
      chk("m_last", sl_m, qm.size() == 1);
      chk("m_ready", rdy_m, qm.size() <= 1);
      chk("l_sout", sout_l, ql.size() > 0 ? ql[0] : 1'b0);
      chk("l_valid", sv_l, ql.size() > 0);
      chk("l_busy", busy_l, ql.size() > 0);
      chk("l_last", sl_l, ql.size() == 1);
      chk("l_ready", rdy_l, ql.size() <= 1);
   endtask

   task automatic tick();
      acc_m  = lv_m && qm.size() <= 1;
      acc_l  = lv_l && ql.size() <= 1;
      prev_m = qm.size() > 0 ? qm[0] : 1'b0;
      @(posedge clk);
      if (qm.size() > 0) qm.delete(0);
      if (ql.size() > 0) ql.delete(0);
      if (acc_m) for (int i = 7; i >= 0; i--) qm.push_back(din_m[i]);
      if (acc_l) for (int i = 0; i < 8; i++) ql.push_back(din_l[i]);
      #1;
      check_outs();
      chk("chain", chain_q, prev_m);
   endtask

   task automatic send_m(input logic [7:0] w, output int t);
      din_m = w;
      lv_m  = 1'b1;
      t     = 0;
      do begin
         tick();
         t++;
      end while (!acc_m && t < 40);
      chk("send_m_accept", acc_m, 1'b1);
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      lv_m = 1'b0;
      lv_l = 1'b0;
      din_m = 'x;
      din_l = 'x;
      #1;
      qm.delete();
      ql.delete();
      check_outs();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #2;
      do_reset();
      tick();
      tick();
      // single word on both instances
      din_m = 8'hA5; lv_m = 1'b1;
      din_l = 8'h01; lv_l = 1'b1;
      tick();
      chk("acc_A5", acc_m, 1'b1);
      chk("acc_01", acc_l, 1'b1);
      lv_m = 1'b0; din_m = 'x;
      lv_l = 1'b0; din_l = 'x;
      for (int i = 0; i < 8; i++) begin
         col[7-i] = sout_m;
         col_l[i] = sout_l;
         tick();
      end
      chk("A5_bits", col, 8'hA5);
      chk("01_bits_lsb", col_l, 8'h01);
      tick();
      tick();
      // back-to-back with load_valid held high
      send_m(8'hFF, waited);
      send_m(8'h00, waited);
      chk("b2b_wait", waited[7:0], 8'd8);
      lv_m = 1'b0; din_m = 'x;
      repeat (9) tick();
      // backpressure: new word offered during bit 3
      send_m(8'h5A, waited);
      lv_m = 1'b0; din_m = 'x;
      repeat (3) tick();
      send_m(8'h3C, waited);
      chk("bp_wait", waited[7:0], 8'd5);
      lv_m = 1'b0; din_m = 'x;
      repeat (10) tick();
      // random traffic on both instances
      for (int k = 0; k < 400; k++) begin
         if (!lv_m && $urandom_range(2) == 0) begin lv_m = 1'b1; din_m = 8'($urandom); end
         if (!lv_l && $urandom_range(2) == 0) begin lv_l = 1'b1; din_l = 8'($urandom); end
         tick();
         if (acc_m) begin lv_m = 1'b0; din_m = 'x; end
         if (acc_l) begin lv_l = 1'b0; din_l = 'x; end
      end
      lv_m = 1'b0; din_m = 'x;
      lv_l = 1'b0; din_l = 'x;
      repeat (10) tick();
      // reset after four bits, then a clean word
      send_m(8'hF0, waited);
      lv_m = 1'b0; din_m = 'x;
      repeat (3) tick();
      do_reset();
      tick();
      send_m(8'h81, waited);
      lv_m = 1'b0; din_m = 'x;
      for (int i = 7; i >= 0; i--) begin
         col[i] = sout_m;
         tick();
      end
      chk("81_after_reset", col, 8'h81);
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
